// File: rtl/ifid_hazard_ctrl.sv
// IF/ID pipeline control: PC advance, IF/ID load/hold/flush and ID/EX bubble from load-use, branch and fetch-wait.
// Latency: outputs are combinational from state and inputs; the state, wait counter and sticky timeout update on each clk edge.
// Backpressure: a load-use hazard holds PC and IF/ID; a slow fetch holds PC and feeds NOPs into IF/ID.
// Optional build macro IFID_HAZ_PERF_EN adds saturating stall/flush perf counters (tied to 0 otherwise).
module ifid_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_rt,
    input  logic [REG_W-1:0] IFID_rs,
    input  logic [REG_W-1:0] IFID_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IF_flush,
    output logic             IDEX_bubble,
    output logic             fetch_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // RUN: fetch data arrives normally; WAIT: fetch outstanding;
    // REDIR: the outstanding fetch was issued before a redirect and is stale.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_timeout_q, fetch_timeout_d;
    logic             luh;

    // Load-use hazard: the load in EX writes a register the ID instruction reads (r0 never hazards).
    always_comb begin
        luh = IDEX_MemRead && (IDEX_rt != '0) &&
              ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
    end

    // Next state and pipeline controls; priority is load-use, branch, fetch-wait, stale data, normal.
    always_comb begin
        state_d     = state_q;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IF_flush    = 1'b0;
        IDEX_bubble = 1'b0;
        if (!reset) begin
            // Safe values while held in reset: PC frozen, NOP into IF/ID, bubble into ID/EX.
            state_d     = S_RUN;
            PC_write    = 1'b0;
            IF_flush    = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (luh) begin
            // Hold everything upstream; a branch in ID is re-evaluated after the stall.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_bubble = 1'b1;
        end else if (branch_taken) begin
            // Redirect; if the wrong-path fetch is still in flight its data must be dropped.
            IF_flush = 1'b1;
            state_d  = imem_ready ? S_RUN : S_REDIR;
        end else if (!imem_ready) begin
            PC_write = 1'b0;
            IF_flush = 1'b1;
            if (state_q == S_RUN) begin
                state_d = S_WAIT;
            end
        end else begin
            case (state_q)
                S_REDIR: begin
                    // Data that just arrived is from before the redirect: discard it and re-fetch the target.
                    PC_write = 1'b0;
                    IF_flush = 1'b1;
                    state_d  = S_RUN;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // Fetch-wait counter (saturating) and sticky timeout flag.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (imem_ready) begin
            wait_cnt_d = '0;
        end else if ((state_q != S_RUN) && (wait_cnt_q < WAIT_LIM)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        fetch_timeout_d = fetch_timeout_q || (wait_cnt_d == WAIT_LIM);
    end

    // State, wait counter and timeout registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_RUN;
            wait_cnt_q      <= '0;
            fetch_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

    assign fetch_timeout = fetch_timeout_q;

`ifdef IFID_HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating perf counters: load-use stall cycles and IF/ID flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (luh && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (IF_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: directed vector table, multi-cycle corner sequences,
// then random stimulus against a behavioural model of the pipeline-control rules.
module tb_ifid_hazard_ctrl;

    localparam int REG_W    = 5;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_rt;
    logic [REG_W-1:0] IFID_rs;
    logic [REG_W-1:0] IFID_rt;
    logic             branch_taken;
    logic             imem_ready;
    logic             PC_write;
    logic             IFID_write;
    logic             IF_flush;
    logic             IDEX_bubble;
    logic             fetch_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    ifid_hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_rt      (IDEX_rt),
        .IFID_rs      (IFID_rs),
        .IFID_rt      (IFID_rt),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .IF_flush     (IF_flush),
        .IDEX_bubble  (IDEX_bubble),
        .fetch_timeout(fetch_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: is a fetch outstanding, is it stale, how long has it waited.
    bit m_fetch_wait;
    bit m_stale;
    int m_wait;
    bit m_timeout;
    int m_stalls;
    int m_flushes;

    // Outputs captured in the last step: {PC_write, IFID_write, IF_flush, IDEX_bubble}.
    logic [3:0] cap;
    logic       cap_to;
    logic [CNT_W-1:0] cap_stall;
    logic [CNT_W-1:0] cap_flush;

    typedef struct {
        logic       mr;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] rt2;
        logic       br;
        logic       rdy;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_fetch_wait = 0;
        m_stale      = 0;
        m_wait       = 0;
        m_timeout    = 0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    function automatic logic [31:0] exp_perf(input int v);
`ifdef IFID_HAZ_PERF_EN
        return (v > 65535) ? 32'd65535 : 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // One clock cycle: drive inputs (called at posedge+1), check at negedge, advance the model.
    task automatic step(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rt2, input logic br, input logic rdy);
        bit         luh;
        logic [3:0] e;
        IDEX_MemRead = mr;
        IDEX_rt      = rt;
        IFID_rs      = rs;
        IFID_rt      = rt2;
        branch_taken = br;
        imem_ready   = rdy;
        @(negedge clk);
        cap       = {PC_write, IFID_write, IF_flush, IDEX_bubble};
        cap_to    = fetch_timeout;
        cap_stall = stall_cnt;
        cap_flush = flush_cnt;
        luh = mr && (rt != 0) && ((rt == rs) || (rt == rt2));
        if (luh)                  e = 4'b0001;
        else if (br)              e = 4'b1110;
        else if (!rdy || m_stale) e = 4'b0110;
        else                      e = 4'b1100;
        check("model_ctl", 32'(cap), 32'(e));
        check("model_timeout", 32'(cap_to), 32'(m_timeout));
        check("flush_with_hold", 32'(IF_flush && !IFID_write), 32'd0);
        check("model_stall_cnt", 32'(cap_stall), exp_perf(m_stalls));
        check("model_flush_cnt", 32'(cap_flush), exp_perf(m_flushes));
        // Wait accounting uses the situation at the start of the cycle.
        if (rdy) m_wait = 0;
        else if (m_fetch_wait || m_stale) m_wait = (m_wait + 1 > WAIT_MAX) ? WAIT_MAX : m_wait + 1;
        if (m_wait == WAIT_MAX) m_timeout = 1;
        if (luh) m_stalls++;
        if (e[1]) m_flushes++;
        if (!luh) begin
            if (br) begin
                m_stale      = !rdy;
                m_fetch_wait = 0;
            end else if (!rdy) begin
                if (!m_stale) m_fetch_wait = 1;
            end else begin
                m_stale      = 0;
                m_fetch_wait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, rdy);
    endtask

    // Async reset pulse starting mid-cycle; outputs and registers checked while reset is held.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        check("rst_ctl", 32'({PC_write, IFID_write, IF_flush, IDEX_bubble}), 32'b0111);
        check("rst_timeout", 32'(fetch_timeout), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        reset        = 1'b0;
        IDEX_MemRead = 1'b0;
        IDEX_rt      = '0;
        IFID_rs      = '0;
        IFID_rt      = '0;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        model_clear();

        tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b1, 4'b0001};
        tbl[1] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 4'b1100};
        tbl[2] = '{1'b1, 5'd7,  5'd1,  5'd7, 1'b0, 1'b1, 4'b0001};
        tbl[3] = '{1'b0, 5'd5,  5'd5,  5'd5, 1'b0, 1'b1, 4'b1100};
        tbl[4] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 1'b1, 4'b0001};
        tbl[5] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 4'b1110};
        tbl[6] = '{1'b1, 5'd3,  5'd4,  5'd2, 1'b0, 1'b1, 4'b1100};
        tbl[7] = '{1'b1, 5'd31, 5'd31, 5'd9, 1'b0, 1'b1, 4'b0001};

        // Reset state.
        #12;
        check("rst_ctl", 32'({PC_write, IFID_write, IF_flush, IDEX_bubble}), 32'b0111);
        check("rst_timeout", 32'(fetch_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed vectors, all from RUN with fetch data ready.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].mr, tbl[i].rt, tbl[i].rs, tbl[i].rt2, tbl[i].br, tbl[i].rdy);
            check($sformatf("tbl%0d", i), 32'(cap), 32'(tbl[i].exp));
        end

        // Perf: two load-use stalls plus one branch from a clean reset.
        do_reset();
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        idle(1'b1);
`ifdef IFID_HAZ_PERF_EN
        check("perf_stall", 32'(cap_stall), 32'd2);
        check("perf_flush", 32'(cap_flush), 32'd1);
`else
        check("perf_stall_off", 32'(cap_stall), 32'd0);
        check("perf_flush_off", 32'(cap_flush), 32'd0);
`endif

        // Three cycles of fetch wait, resume on the fourth.
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check($sformatf("wait%0d", i), 32'({cap[3], cap[1]}), 32'b01);
        end
        idle(1'b1);
        check("wait_resume", 32'({cap[3], cap[1]}), 32'b10);

        // Branch with fetch outstanding; ready arrives two cycles later with stale data.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        check("redir_branch", 32'(cap), 32'b1110);
        idle(1'b0);
        idle(1'b1);
        check("redir_stale", 32'(cap), 32'b0110);
        idle(1'b1);
        check("redir_resume", 32'(cap), 32'b1100);

        // Timeout: hold ready low well past WAIT_MAX, then let ready return.
        check("to_clear", 32'(fetch_timeout), 32'd0);
        for (int i = 0; i < 7; i++) idle(1'b0);
        check("to_set", 32'(cap_to), 32'd1);
        idle(1'b1);
        idle(1'b1);
        check("to_sticky", 32'(cap_to), 32'd1);

        // Reset in the middle of a wait clears the timeout and returns to RUN.
        idle(1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b1);
        check("post_rst_run", 32'(cap), 32'b1100);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0) && (i % 100 < 90));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
